ristretto_if_stage: RTL



---
 rtl/ristretto_if_stage_pkg.sv | 16 +
 rtl/ristretto_pc_gen.sv | 40 ++++
 rtl/ristretto_if_stage.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/ristretto_if_stage_pkg.sv
// Shared types and constants for the ristretto instruction fetch stage.
package ristretto_if_stage_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        HOLD,
        HALT
    } if_state_t;

    localparam logic [31:0] NOP_INSTR         = 32'h0000_0013;
    localparam int unsigned PC_INCR           = 4;
    localparam logic [31:0] BOOT_ADDR_DEFAULT = 32'h0000_0000;

endpackage : ristretto_if_stage_pkg

// File: rtl/ristretto_pc_gen.sv
// Fetch PC register with sequential increment and redirect load.
module ristretto_pc_gen
    import ristretto_if_stage_pkg::*;
#(
    parameter int unsigned          AddrWidth = 32,
    parameter logic [AddrWidth-1:0] BootAddr  = '0
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic                 load_en_i,
    input  logic [AddrWidth-1:0] load_pc_i,
    input  logic                 incr_en_i,
    output logic [AddrWidth-1:0] pc_o,
    output logic [AddrWidth-1:0] pc_incr_o
);

    logic [AddrWidth-1:0] pc_q, pc_d;

    // Wraps modulo 2^AddrWidth.
    assign pc_incr_o = pc_q + AddrWidth'(PC_INCR);
    assign pc_o      = pc_q;

    always_comb begin
        pc_d = pc_q;
        if (load_en_i) begin
            pc_d = load_pc_i;
        end else if (incr_en_i) begin
            pc_d = pc_incr_o;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            pc_q <= BootAddr;
        end else begin
            pc_q <= pc_d;
        end
    end

endmodule : ristretto_pc_gen

// File: rtl/ristretto_if_stage.sv
// Instruction fetch stage: imem req/gnt/rvalid handshake, redirect handling
// and delivery of instruction, PC and PC+4 to decode.
module ristretto_if_stage
    import ristretto_if_stage_pkg::*;
#(
    parameter int unsigned          DataWidth = 32,
    parameter int unsigned          AddrWidth = 32,
    parameter logic [AddrWidth-1:0] BootAddr  = BOOT_ADDR_DEFAULT
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic                 if_stall_i,
    input  logic                 if_branch_en_i,
    input  logic [AddrWidth-1:0] if_branch_target_i,
    output logic                 imem_req_o,
    output logic [AddrWidth-1:0] imem_addr_o,
    input  logic                 imem_gnt_i,
    input  logic                 imem_rvalid_i,
    input  logic [DataWidth-1:0] imem_rdata_i,
    output logic [DataWidth-1:0] if_instr_o,
    output logic [AddrWidth-1:0] if_pc_o,
    output logic [AddrWidth-1:0] if_next_pc_o,
    output logic                 if_new_instr_o,
    output logic                 if_stage_busy_o,
    output logic                 if_misaligned_o
);

    if_state_t            state_q, state_d;
    logic [DataWidth-1:0] instr_q, instr_d;
    logic [AddrWidth-1:0] ipc_q, ipc_d;
    logic [AddrWidth-1:0] inpc_q, inpc_d;
    logic                 new_q, new_d;
    logic                 mis_q, mis_d;
    logic                 flush_q, flush_d;

    logic                 pc_load;
    logic                 pc_incr_en;
    logic [AddrWidth-1:0] pc;
    logic [AddrWidth-1:0] pc_plus4;
    logic                 br_aligned;

    ristretto_pc_gen #(
        .AddrWidth(AddrWidth),
        .BootAddr (BootAddr)
    ) u_pc_gen (
        .clk_i    (clk_i),
        .rstn_i   (rstn_i),
        .load_en_i(pc_load),
        .load_pc_i(if_branch_target_i),
        .incr_en_i(pc_incr_en),
        .pc_o     (pc),
        .pc_incr_o(pc_plus4)
    );

    assign br_aligned = (if_branch_target_i[1:0] == 2'b00);

    always_comb begin
        state_d    = state_q;
        instr_d    = instr_q;
        ipc_d      = ipc_q;
        inpc_d     = inpc_q;
        new_d      = 1'b0;
        mis_d      = mis_q;
        flush_d    = flush_q;
        pc_load    = 1'b0;
        pc_incr_en = 1'b0;

        if (if_branch_en_i) begin
            // A misaligned target never moves the PC; an outstanding
            // transaction is still drained (flushed) before halting.
            if (br_aligned) begin
                mis_d   = 1'b0;
                pc_load = 1'b1;
            end else begin
                mis_d = 1'b1;
            end
            case (state_q)
                REQ: begin
                    if (imem_gnt_i) begin
                        flush_d = 1'b1;
                        state_d = WAIT;
                    end else begin
                        state_d = br_aligned ? IDLE : HALT;
                    end
                end
                WAIT: begin
                    if (imem_rvalid_i) begin
                        flush_d = 1'b0;
                        state_d = br_aligned ? REQ : HALT;
                    end else begin
                        flush_d = 1'b1;
                    end
                end
                default: state_d = br_aligned ? REQ : HALT;
            endcase
        end else begin
            case (state_q)
                IDLE: state_d = REQ;
                REQ: begin
                    if (imem_gnt_i) begin
                        state_d = WAIT;
                    end
                end
                WAIT: begin
                    if (imem_rvalid_i) begin
                        if (flush_q) begin
                            flush_d = 1'b0;
                            state_d = mis_q ? HALT : REQ;
                        end else begin
                            instr_d    = imem_rdata_i;
                            ipc_d      = pc;
                            inpc_d     = pc_plus4;
                            pc_incr_en = 1'b1;
                            if (if_stall_i) begin
                                state_d = HOLD;
                            end else begin
                                new_d   = 1'b1;
                                state_d = REQ;
                            end
                        end
                    end
                end
                HOLD: begin
                    if (!if_stall_i) begin
                        new_d   = 1'b1;
                        state_d = REQ;
                    end
                end
                HALT:    state_d = HALT;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= IDLE;
            instr_q <= DataWidth'(NOP_INSTR);
            ipc_q   <= BootAddr;
            inpc_q  <= BootAddr + AddrWidth'(PC_INCR);
            new_q   <= 1'b0;
            mis_q   <= 1'b0;
            flush_q <= 1'b0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            ipc_q   <= ipc_d;
            inpc_q  <= inpc_d;
            new_q   <= new_d;
            mis_q   <= mis_d;
            flush_q <= flush_d;
        end
    end

    assign imem_req_o      = (state_q == REQ);
    assign imem_addr_o     = pc;
    assign if_stage_busy_o = (state_q == REQ) || (state_q == WAIT);
    assign if_instr_o      = instr_q;
    assign if_pc_o         = ipc_q;
    assign if_next_pc_o    = inpc_q;
    assign if_new_instr_o  = new_q;
    assign if_misaligned_o = mis_q;

endmodule : ristretto_if_stage
